// File: rtl/gfx_wr_arbiter.sv
// Write-path arbiter: two graphics requesters share one address FIFO and one
// write-data FIFO; each transaction is one address plus two data beats, never split.
module gfx_wr_arbiter #(
  parameter int AW = 31,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] le_af_addr_din,
  input  logic          le_af_wr_en,
  input  logic [127:0]  le_wdf_din,
  input  logic [15:0]   le_wdf_mask_din,
  input  logic          le_wdf_wr_en,
  output logic          le_af_full,
  output logic          le_wdf_full,
  input  logic [AW-1:0] ff_af_addr_din,
  input  logic          ff_af_wr_en,
  input  logic [127:0]  ff_wdf_din,
  input  logic [15:0]   ff_wdf_mask_din,
  input  logic          ff_wdf_wr_en,
  output logic          ff_af_full,
  output logic          ff_wdf_full,
  input  logic          af_full,
  input  logic          wdf_full,
  output logic [AW-1:0] af_addr_din,
  output logic          af_wr_en,
  output logic [127:0]  wdf_din,
  output logic [15:0]   wdf_mask_din,
  output logic          wdf_wr_en,
  output logic [CW-1:0] le_txn_count,
  output logic [CW-1:0] ff_txn_count,
  output logic          protocol_err,
  output logic [2:0]    dbg_state
);

  // Handshake: a requester's write is taken in a cycle only when its wr_en is high
  // and the full flag this block returns to it is low; the FIFO side is a plain
  // write strobe gated by the FIFO's own full flag.

  typedef enum logic {ARB = 1'b0, BEAT2 = 1'b1} state_t;

  state_t        state, state_nxt;
  logic          owner, owner_nxt;
  logic          last, last_nxt;
  logic          sel, cur, cur_af, cur_wdf, grant;
  logic          le_inc, ff_inc, err_set;
  logic [CW-1:0] le_cnt, ff_cnt;
  logic          err_q;

  // Requester pick while arbitrating; idle cycles keep pointing at the last owner.
  always_comb begin
    sel = owner;
    case ({ff_af_wr_en, le_af_wr_en})
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~last;
      default: sel = owner;
    endcase
  end

  assign cur     = (state == BEAT2) ? owner : sel;
  assign cur_af  = cur ? ff_af_wr_en  : le_af_wr_en;
  assign cur_wdf = cur ? ff_wdf_wr_en : le_wdf_wr_en;

  assign af_addr_din  = cur ? ff_af_addr_din  : le_af_addr_din;
  assign wdf_din      = cur ? ff_wdf_din      : le_wdf_din;
  assign wdf_mask_din = cur ? ff_wdf_mask_din : le_wdf_mask_din;

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    last_nxt    = last;
    grant       = 1'b0;
    af_wr_en    = 1'b0;
    wdf_wr_en   = 1'b0;
    le_af_full  = 1'b1;
    le_wdf_full = 1'b1;
    ff_af_full  = 1'b1;
    ff_wdf_full = 1'b1;
    le_inc      = 1'b0;
    ff_inc      = 1'b0;
    err_set     = 1'b0;
    if (!rst) begin
      case (state)
        ARB: begin
          // Beat 1 travels with the address, so both FIFOs must have room.
          grant     = cur_af & ~af_full & ~wdf_full;
          af_wr_en  = grant;
          wdf_wr_en = grant;
          err_set   = cur_wdf & ~cur_af;
          if (cur) begin
            ff_af_full  = af_full;
            ff_wdf_full = wdf_full;
          end else begin
            le_af_full  = af_full;
            le_wdf_full = wdf_full;
          end
          if (grant) begin
            state_nxt = BEAT2;
            owner_nxt = sel;
          end
        end
        BEAT2: begin
          wdf_wr_en = cur_wdf & ~wdf_full;
          err_set   = cur_af;
          if (owner) ff_wdf_full = wdf_full;
          else       le_wdf_full = wdf_full;
          if (wdf_wr_en) begin
            state_nxt = ARB;
            last_nxt  = owner;
            le_inc    = ~owner;
            ff_inc    = owner;
          end
        end
        default: state_nxt = ARB;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ARB;
      owner  <= 1'b0;
      last   <= 1'b1;
      le_cnt <= '0;
      ff_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      if (le_inc) le_cnt <= le_cnt + 1'b1;
      if (ff_inc) ff_cnt <= ff_cnt + 1'b1;
      err_q <= err_q | err_set;
    end
  end

  assign le_txn_count = le_cnt;
  assign ff_txn_count = ff_cnt;
  assign protocol_err = err_q;
  assign dbg_state    = {last, owner, state == BEAT2};

endmodule

// File: tb/tb_gfx_wr_arbiter.sv
// Directed bench for gfx_wr_arbiter: hand-computed grants, backpressure,
// stall, protocol error and mid-transaction reset.
module tb_gfx_wr_arbiter;
  localparam int AW = 31;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] le_af_addr_din, ff_af_addr_din;
  logic          le_af_wr_en, ff_af_wr_en, le_wdf_wr_en, ff_wdf_wr_en;
  logic [127:0]  le_wdf_din, ff_wdf_din;
  logic [15:0]   le_wdf_mask_din, ff_wdf_mask_din;
  logic          le_af_full, le_wdf_full, ff_af_full, ff_wdf_full;
  logic          af_full, wdf_full;
  logic [AW-1:0] af_addr_din;
  logic          af_wr_en, wdf_wr_en;
  logic [127:0]  wdf_din;
  logic [15:0]   wdf_mask_din;
  logic [CW-1:0] le_txn_count, ff_txn_count;
  logic          protocol_err;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  gfx_wr_arbiter #(.AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .le_af_addr_din(le_af_addr_din), .le_af_wr_en(le_af_wr_en),
    .le_wdf_din(le_wdf_din), .le_wdf_mask_din(le_wdf_mask_din),
    .le_wdf_wr_en(le_wdf_wr_en), .le_af_full(le_af_full), .le_wdf_full(le_wdf_full),
    .ff_af_addr_din(ff_af_addr_din), .ff_af_wr_en(ff_af_wr_en),
    .ff_wdf_din(ff_wdf_din), .ff_wdf_mask_din(ff_wdf_mask_din),
    .ff_wdf_wr_en(ff_wdf_wr_en), .ff_af_full(ff_af_full), .ff_wdf_full(ff_wdf_full),
    .af_full(af_full), .wdf_full(wdf_full),
    .af_addr_din(af_addr_din), .af_wr_en(af_wr_en),
    .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en),
    .le_txn_count(le_txn_count), .ff_txn_count(ff_txn_count),
    .protocol_err(protocol_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    le_af_wr_en = 1'b0; le_wdf_wr_en = 1'b0;
    ff_af_wr_en = 1'b0; ff_wdf_wr_en = 1'b0;
    af_full = 1'b0; wdf_full = 1'b0;
  endtask

  task automatic set_le(input logic [AW-1:0] a, input logic [127:0] d, input logic [15:0] m);
    le_af_addr_din = a; le_wdf_din = d; le_wdf_mask_din = m;
  endtask

  task automatic set_ff(input logic [AW-1:0] a, input logic [127:0] d, input logic [15:0] m);
    ff_af_addr_din = a; ff_wdf_din = d; ff_wdf_mask_din = m;
  endtask

  initial begin
    logic g;
    logic [AW-1:0] la, fa;
    logic [127:0]  ld, fd;

    rst = 1'b1;
    idle_inputs();
    set_le('0, '0, '0);
    set_ff('0, '0, '0);
    le_af_wr_en = 1'b1; le_wdf_wr_en = 1'b1;
    tick();
    tick();
    // reset holds everything off even with a request present
    check("rst_af_wr_en", af_wr_en, 0);
    check("rst_wdf_wr_en", wdf_wr_en, 0);
    check("rst_le_af_full", le_af_full, 1);
    check("rst_le_wdf_full", le_wdf_full, 1);
    check("rst_ff_af_full", ff_af_full, 1);
    check("rst_ff_wdf_full", ff_wdf_full, 1);
    check("rst_state", dbg_state, 3'b100);
    check("rst_le_cnt", le_txn_count, 0);
    check("rst_ff_cnt", ff_txn_count, 0);
    check("rst_err", protocol_err, 0);
    idle_inputs();
    rst = 1'b0;
    tick();

    // single le transaction
    set_le(31'h0400_1000, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 16'h00F0);
    le_af_wr_en = 1'b1; le_wdf_wr_en = 1'b1;
    settle();
    check("t1_af_wr_en", af_wr_en, 1);
    check("t1_wdf_wr_en", wdf_wr_en, 1);
    check("t1_addr", af_addr_din, 31'h0400_1000);
    check("t1_data1", wdf_din, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    check("t1_mask", wdf_mask_din, 16'h00F0);
    check("t1_le_af_full", le_af_full, 0);
    check("t1_ff_af_full", ff_af_full, 1);
    tick();
    le_af_wr_en = 1'b0;
    le_wdf_din = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_1111;
    settle();
    check("t1_b2_state", dbg_state, 3'b101);
    check("t1_b2_af_wr_en", af_wr_en, 0);
    check("t1_b2_wdf_wr_en", wdf_wr_en, 1);
    check("t1_b2_data", wdf_din, 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_1111);
    check("t1_b2_le_af_full", le_af_full, 1);
    check("t1_b2_le_wdf_full", le_wdf_full, 0);
    tick();
    idle_inputs();
    settle();
    check("t1_le_cnt", le_txn_count, 1);
    check("t1_state", dbg_state, 3'b000);

    // both request back to back: le served last, so ff, le, ff, ...
    for (int i = 0; i < 8; i++) begin
      g  = (i % 2 == 0);
      la = 31'h0100_0000 + 31'(i);
      fa = 31'h0200_0000 + 31'(i);
      ld = {4{32'hE000_0000 + 32'(i)}};
      fd = {4{32'hF000_0000 + 32'(i)}};
      set_le(la, ld, 16'h0001);
      set_ff(fa, fd, 16'h8000);
      le_af_wr_en = 1'b1; le_wdf_wr_en = 1'b1;
      ff_af_wr_en = 1'b1; ff_wdf_wr_en = 1'b1;
      settle();
      check("rr_af_wr_en", af_wr_en, 1);
      check("rr_addr", af_addr_din, g ? fa : la);
      check("rr_loser_af_full", g ? le_af_full : ff_af_full, 1);
      check("rr_loser_wdf_full", g ? le_wdf_full : ff_wdf_full, 1);
      check("rr_winner_af_full", g ? ff_af_full : le_af_full, 0);
      tick();
      if (g) ff_af_wr_en = 1'b0; else le_af_wr_en = 1'b0;
      settle();
      check("rr_b2_wdf_wr_en", wdf_wr_en, 1);
      check("rr_b2_af_wr_en", af_wr_en, 0);
      check("rr_b2_data", wdf_din, g ? fd : ld);
      check("rr_b2_loser_full", g ? le_wdf_full : ff_wdf_full, 1);
      tick();
    end
    idle_inputs();
    settle();
    check("rr_le_cnt", le_txn_count, 5);
    check("rr_ff_cnt", ff_txn_count, 4);
    check("rr_err", protocol_err, 0);

    // le granted alone, then beat 2 stalls on wdf_full while ff waits
    set_le(31'h0300_0000, 128'h5, 16'h0);
    set_ff(31'h0300_0100, 128'h6, 16'h0);
    le_af_wr_en = 1'b1; le_wdf_wr_en = 1'b1;
    settle();
    check("st_grant_le", af_wr_en, 1);
    tick();
    le_af_wr_en = 1'b0;
    ff_af_wr_en = 1'b1; ff_wdf_wr_en = 1'b1;
    wdf_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("st_wdf_wr_en", wdf_wr_en, 0);
      check("st_af_wr_en", af_wr_en, 0);
      check("st_ff_af_full", ff_af_full, 1);
      check("st_le_wdf_full", le_wdf_full, 1);
      check("st_state", dbg_state[0], 1);
      tick();
    end
    wdf_full = 1'b0;
    settle();
    check("st_b2_wdf_wr_en", wdf_wr_en, 1);
    check("st_b2_data", wdf_din, 128'h5);
    tick();
    le_wdf_wr_en = 1'b0;
    settle();
    check("st_ff_grant", af_wr_en, 1);
    check("st_ff_addr", af_addr_din, 31'h0300_0100);
    tick();
    ff_af_wr_en = 1'b0;
    settle();
    check("st_ff_b2", wdf_wr_en, 1);
    tick();
    idle_inputs();
    settle();
    check("st_le_cnt", le_txn_count, 6);
    check("st_ff_cnt", ff_txn_count, 5);

    // af_full blocks le; ff then wins once af_full drops
    af_full = 1'b1;
    le_af_wr_en = 1'b1; le_wdf_wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("af_blk_af_wr_en", af_wr_en, 0);
      check("af_blk_wdf_wr_en", wdf_wr_en, 0);
      check("af_blk_le_af_full", le_af_full, 1);
      check("af_blk_state", dbg_state[0], 0);
      tick();
    end
    le_af_wr_en = 1'b0; le_wdf_wr_en = 1'b0;
    ff_af_wr_en = 1'b1; ff_wdf_wr_en = 1'b1;
    af_full = 1'b0;
    settle();
    check("af_ff_grant", af_wr_en, 1);
    check("af_ff_addr", af_addr_din, 31'h0300_0100);
    check("af_ff_af_full", ff_af_full, 0);
    check("af_le_af_full", le_af_full, 1);
    tick();
    ff_af_wr_en = 1'b0;
    settle();
    check("af_ff_b2", wdf_wr_en, 1);
    tick();
    idle_inputs();
    settle();
    check("af_ff_cnt", ff_txn_count, 6);
    check("af_err", protocol_err, 0);

    // ff (current owner pointer) writes data with no address while idle
    ff_wdf_wr_en = 1'b1;
    settle();
    check("pe_no_write", wdf_wr_en, 0);
    tick();
    ff_wdf_wr_en = 1'b0;
    settle();
    check("pe_set", protocol_err, 1);
    tick();
    tick();
    tick();
    check("pe_held", protocol_err, 1);

    // reset in the middle of a le transaction
    set_le(31'h0500_0000, 128'h7, 16'h0);
    le_af_wr_en = 1'b1; le_wdf_wr_en = 1'b1;
    settle();
    check("mr_grant", af_wr_en, 1);
    tick();
    check("mr_locked", dbg_state, 3'b101);
    rst = 1'b1;
    idle_inputs();
    le_wdf_wr_en = 1'b1;
    settle();
    check("mr_rst_wdf_wr_en", wdf_wr_en, 0);
    check("mr_rst_le_wdf_full", le_wdf_full, 1);
    check("mr_cnt_held", le_txn_count, 6);
    tick();
    check("mr_state", dbg_state, 3'b100);
    check("mr_le_cnt", le_txn_count, 0);
    check("mr_ff_cnt", ff_txn_count, 0);
    check("mr_err", protocol_err, 0);
    rst = 1'b0;
    idle_inputs();
    le_af_wr_en = 1'b1; le_wdf_wr_en = 1'b1;
    settle();
    check("mr_after_grant", af_wr_en, 1);
    check("mr_after_addr", af_addr_din, 31'h0500_0000);
    tick();
    le_af_wr_en = 1'b0;
    settle();
    check("mr_after_b2", wdf_wr_en, 1);
    tick();
    idle_inputs();
    settle();
    check("mr_after_cnt", le_txn_count, 1);
    check("mr_after_err", protocol_err, 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
